// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// The receiver uses this package, and the future transmitter will reuse it.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so that an idle-high line does not look like a start bit.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling: it confirms the start bit at mid-bit and then samples every bit at its centre.
// The result and the status pulses are registered, and the output word changes only on a good frame.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  logic                 w_rx_s;
  uart_state_e          r_state, w_state_nxt;
  logic [3:0]           r_s_cnt, w_s_cnt_nxt;
  logic [2:0]           r_n_cnt, w_n_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_parity_err;
  logic                 w_valid_nxt, w_ferr_nxt, w_perr_nxt;
  logic                 w_par_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  // The data bits and the parity bit XOR to PARITY_ODD on a good frame.
  assign w_par_bad = (PARITY_EN != 0) && ((^{r_shift, r_par}) != (PARITY_ODD != 0));

  // NOTE: assigning every output a default first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;

    if (tick && r_state != ST_IDLE) w_s_cnt_nxt = r_s_cnt + 4'd1;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_s_cnt_nxt = 4'd0;
        end
      end
      ST_START: begin
        if (tick && r_s_cnt == MID_SAMPLE) begin
          w_s_cnt_nxt = 4'd0;
          w_n_cnt_nxt = 3'd0;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && r_s_cnt == LAST_SAMPLE) begin
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_s_cnt_nxt = 4'd0;
          if (r_n_cnt == 3'(DATA_BITS - 1))
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          else
            w_n_cnt_nxt = r_n_cnt + 3'd1;
        end
      end
      ST_PARITY: begin
        if (tick && r_s_cnt == LAST_SAMPLE) begin
          w_par_nxt   = w_rx_s;
          w_s_cnt_nxt = 4'd0;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && r_s_cnt == LAST_SAMPLE) begin
          w_ferr_nxt  = !w_rx_s;
          w_perr_nxt  = w_par_bad;
          w_valid_nxt = w_rx_s && !w_par_bad;
          w_s_cnt_nxt = 4'd0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_s_cnt      <= 4'd0;
      r_n_cnt      <= 3'd0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_s_cnt      <= w_s_cnt_nxt;
      r_n_cnt      <= w_n_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par        <= w_par_nxt;
      r_valid      <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_parity_err <= w_perr_nxt;
      if (w_valid_nxt) r_data <= r_shift;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: an 8N1 instance and an 8E1 instance driven with tick every 4 clk (64 clk per bit).
// Expected pulses go into per-instance queues as frames are driven and are compared whenever the DUT pulses.
module tb_uart_rx_oversample;

  localparam int BIT_CLK = 64;

  typedef struct {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    int         stop_low;
    int         gap;
    logic       exp_v;
    logic       exp_fe;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic tick;
  logic tick_en;
  logic rx, rx_p;
  logic [7:0] data, data_p;
  logic valid, frame_err, parity_err, busy;
  logic valid_p, frame_err_p, parity_err_p, busy_p;

  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_cnt = 0;
  exp_t sb_q[$];
  exp_t sbp_q[$];
  logic [7:0] last_d  = 8'h00;
  logic [7:0] last_dp = 8'h00;
  vec_t vecs[4];

  uart_rx_oversample #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  uart_rx_oversample #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rstn(rstn), .tick(tick), .rx(rx_p), .data(data_p), .valid(valid_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      tick = tick_en && ((tick_cnt % 4) == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the 8N1 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid || frame_err || parity_err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, valid, frame_err, parity_err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("valid", {31'd0, valid}, {31'd0, e.v});
          check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          check("data", {24'd0, data}, {24'd0, e.d});
        end
      end
    end
  end

  // Scoreboard for the parity instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_p || frame_err_p || parity_err_p) begin
        if (sbp_q.size() == 0) begin
          check("unexpected_pulse_p", {29'd0, valid_p, frame_err_p, parity_err_p}, 32'd0);
        end else begin
          e = sbp_q.pop_front();
          check("valid_p", {31'd0, valid_p}, {31'd0, e.v});
          check("frame_err_p", {31'd0, frame_err_p}, {31'd0, e.fe});
          check("parity_err_p", {31'd0, parity_err_p}, {31'd0, e.pe});
          check("data_p", {24'd0, data_p}, {24'd0, e.d});
        end
      end
    end
  end

  task automatic drive(input bit par_line, input logic b, input int n);
    if (par_line) rx_p = b;
    else rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit par_line, input logic [7:0] d, input bit with_par,
                            input logic pbit, input int stop_low, input exp_t e);
    if (par_line) sbp_q.push_back(e);
    else sb_q.push_back(e);
    drive(par_line, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(par_line, d[i], BIT_CLK);
    if (with_par) drive(par_line, pbit, BIT_CLK);
    if (stop_low > 0) begin
      drive(par_line, 1'b0, stop_low);
      drive(par_line, 1'b1, BIT_CLK - stop_low);
    end else begin
      drive(par_line, 1'b1, BIT_CLK);
    end
  endtask

  // Expected outcome of a parity frame on the even-parity instance.
  task automatic send_par_frame(input logic [7:0] d, input logic pbit);
    exp_t e;
    logic bad;
    bad  = ((^d) ^ pbit) != 1'b0;
    e.v  = !bad;
    e.fe = 1'b0;
    e.pe = bad;
    e.d  = bad ? last_dp : d;
    if (!bad) last_dp = d;
    send_frame(1'b1, d, 1'b1, pbit, 0, e);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{d: 8'h55, stop_low: 0,  gap: 0,  exp_v: 1'b1, exp_fe: 1'b0};
    vecs[1] = '{d: 8'hA3, stop_low: 0,  gap: 64, exp_v: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{d: 8'h3C, stop_low: 48, gap: 64, exp_v: 1'b0, exp_fe: 1'b1};
    vecs[3] = '{d: 8'h0F, stop_low: 0,  gap: 64, exp_v: 1'b1, exp_fe: 1'b0};

    tick_en = 1'b1;
    rx      = 1'b0;
    rx_p    = 1'b1;
    rstn    = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back good frames, then a stop bit held low, then a recovery frame.
    for (int i = 0; i < 4; i++) begin
      e.v  = vecs[i].exp_v;
      e.fe = vecs[i].exp_fe;
      e.pe = 1'b0;
      e.d  = vecs[i].exp_v ? vecs[i].d : last_d;
      if (vecs[i].exp_v) last_d = vecs[i].d;
      send_frame(1'b0, vecs[i].d, 1'b0, 1'b0, vecs[i].stop_low, e);
      repeat (vecs[i].gap) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    check("table_missing_pulses", sb_q.size(), 32'd0);
    check("table_final_data", {24'd0, data}, {24'd0, last_d});

    // Short glitch: START is entered, then rejected at mid-bit.
    drive(1'b0, 1'b0, 8);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    drive(1'b0, 1'b0, 12);
    drive(1'b0, 1'b1, 100);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_data_kept", {24'd0, data}, {24'd0, last_d});

    // Reset pulse during data bit 4 of 0xFF, then a clean 0x12.
    drive(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, BIT_CLK);
    drive(1'b0, 1'b1, 30);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'd0);
    last_d  = 8'h00;
    last_dp = 8'h00;
    rstn = 1'b1;
    drive(1'b0, 1'b1, BIT_CLK - 30 - 3 + 4 * BIT_CLK);
    check("after_abort_busy", {31'd0, busy}, 32'd0);
    e = '{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'h12};
    last_d = 8'h12;
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 0, e);
    repeat (64) @(negedge clk);
    check("reset_missing_pulses", sb_q.size(), 32'd0);

    // Tick stalled for 500 clk during bit 2 of 0x81, line held with it.
    e = '{v: 1'b1, fe: 1'b0, pe: 1'b0, d: 8'h81};
    sb_q.push_back(e);
    last_d = 8'h81;
    drive(1'b0, 1'b0, BIT_CLK);
    drive(1'b0, 1'b1, BIT_CLK);
    drive(1'b0, 1'b0, BIT_CLK);
    drive(1'b0, 1'b0, 20);
    tick_en = 1'b0;
    drive(1'b0, 1'b0, 500);
    check("stall_busy_held", {31'd0, busy}, 32'd1);
    tick_en = 1'b1;
    drive(1'b0, 1'b0, BIT_CLK - 20);
    for (int i = 3; i < 8; i++) drive(1'b0, (i == 7) ? 1'b1 : 1'b0, BIT_CLK);
    drive(1'b0, 1'b1, BIT_CLK);
    repeat (64) @(negedge clk);
    check("stall_missing_pulses", sb_q.size(), 32'd0);
    check("stall_data", {24'd0, data}, 32'h81);

    // Even parity: 0x07 has three ones, so parity bit 1 is good and 0 is bad.
    send_par_frame(8'h07, 1'b1);
    repeat (64) @(negedge clk);
    send_par_frame(8'h07, 1'b0);
    repeat (64) @(negedge clk);
    send_par_frame(8'hC0, 1'b0);
    repeat (64) @(negedge clk);
    check("parity_missing_pulses", sbp_q.size(), 32'd0);
    check("parity_final_data", {24'd0, data_p}, {24'd0, last_dp});
    check("parity_busy_low", {31'd0, busy_p}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
